// File: rtl/fpu_norm_lead0_pipe.sv
// fpu_norm_lead0_pipe
// Two-stage leading-zero count and normalize unit for 64-bit FPU mantissas.
//   S1: leading-zero count built from sixteen nibble counters merged through
//       a binary tree, registered together with the mantissa and tag.
//   S2: left shift of the S1 mantissa by the selected shift amount.
// Valid/ready handshake on both sides; one op per cycle at full throughput.
// Optional feature macro: FPU_NORM_CLAMP_EN adds in_max_shift and limits the
// applied shift to min(lead0, max_shift) while out_lead0 keeps the true count.
module fpu_norm_lead0_pipe (
   input  logic        rclk,
   input  logic        arst_l,
   input  logic        in_vld,
   output logic        in_rdy,
   input  logic [63:0] in_mant,
   input  logic [3:0]  in_tag,
`ifdef FPU_NORM_CLAMP_EN
   input  logic [5:0]  in_max_shift,
`endif
   output logic        out_vld,
   input  logic        out_rdy,
   output logic [63:0] out_mant,
   output logic [5:0]  out_lead0,
   output logic [5:0]  out_shift,
   output logic        out_zero,
   output logic [3:0]  out_tag
);

   // S1 state
   logic        s1_vld;
   logic [63:0] s1_mant;
   logic [3:0]  s1_tag;
   logic [5:0]  s1_lead0;
   logic        s1_zero;
`ifdef FPU_NORM_CLAMP_EN
   logic [5:0]  s1_max_shift;
`endif

   // handshake
   logic s1_load;
   logic s2_adv;
   logic [5:0] shift_sel;

   // leading-zero tree; index 0 is always the more significant half
   logic [15:0] nib_zero;
   logic [1:0]  nib_cnt [16];
   logic [7:0]  l1_zero;
   logic [2:0]  l1_cnt [8];
   logic [3:0]  l2_zero;
   logic [3:0]  l2_cnt [4];
   logic [1:0]  l3_zero;
   logic [4:0]  l3_cnt [2];
   logic [5:0]  lead0_calc;
   logic        zero_calc;

   assign s2_adv  = s1_vld & (~out_vld | out_rdy);
   assign in_rdy  = ~s1_vld | s2_adv;
   assign s1_load = in_vld & in_rdy;

   // Per-nibble count: zero flag, upper-pair-zero as count bit 1, bit 0 from
   // whichever pair holds the first one. An all-zero nibble yields 3, so the
   // merged tree naturally reports 63 for a zero mantissa.
   always_comb begin
      logic [3:0] nib;
      logic       upper_zero;
      nib        = 4'h0;
      upper_zero = 1'b0;
      nib_zero   = 16'h0000;
      nib_cnt    = '{default: 2'b00};
      for (int i = 0; i < 16; i++) begin
         nib         = in_mant[63-4*i -: 4];
         upper_zero  = ~(nib[3] | nib[2]);
         nib_zero[i] = (nib == 4'h0);
         nib_cnt[i]  = {upper_zero, (upper_zero ? ~nib[1] : ~nib[3])};
      end
   end

   // Merge level 1: nibble pairs into byte counts
   always_comb begin
      l1_zero = 8'h00;
      l1_cnt  = '{default: 3'b000};
      for (int i = 0; i < 8; i++) begin
         l1_zero[i] = nib_zero[2*i] & nib_zero[2*i+1];
         l1_cnt[i]  = nib_zero[2*i] ? {1'b1, nib_cnt[2*i+1]} : {1'b0, nib_cnt[2*i]};
      end
   end

   // Merge level 2: bytes into 16-bit counts
   always_comb begin
      l2_zero = 4'h0;
      l2_cnt  = '{default: 4'h0};
      for (int i = 0; i < 4; i++) begin
         l2_zero[i] = l1_zero[2*i] & l1_zero[2*i+1];
         l2_cnt[i]  = l1_zero[2*i] ? {1'b1, l1_cnt[2*i+1]} : {1'b0, l1_cnt[2*i]};
      end
   end

   // Merge levels 3 and 4: 16-bit halves into the final 6-bit count
   always_comb begin
      l3_zero = 2'b00;
      l3_cnt  = '{default: 5'h00};
      for (int i = 0; i < 2; i++) begin
         l3_zero[i] = l2_zero[2*i] & l2_zero[2*i+1];
         l3_cnt[i]  = l2_zero[2*i] ? {1'b1, l2_cnt[2*i+1]} : {1'b0, l2_cnt[2*i]};
      end
      zero_calc  = l3_zero[0] & l3_zero[1];
      lead0_calc = l3_zero[0] ? {1'b1, l3_cnt[1]} : {1'b0, l3_cnt[0]};
   end

   // Shift amount applied in S2: true count, or limited by the exponent cap
   always_comb begin
`ifdef FPU_NORM_CLAMP_EN
      if (s1_lead0 < s1_max_shift) begin
         shift_sel = s1_lead0;
      end else begin
         shift_sel = s1_max_shift;
      end
`else
      shift_sel = s1_lead0;
`endif
   end

   // S1 register: capture on accept, release valid when drained into S2
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         s1_vld       <= 1'b0;
         s1_mant      <= 64'h0;
         s1_tag       <= 4'h0;
         s1_lead0     <= 6'd0;
         s1_zero      <= 1'b0;
`ifdef FPU_NORM_CLAMP_EN
         s1_max_shift <= 6'd0;
`endif
      end else if (s1_load) begin
         s1_vld       <= 1'b1;
         s1_mant      <= in_mant;
         s1_tag       <= in_tag;
         s1_lead0     <= lead0_calc;
         s1_zero      <= zero_calc;
`ifdef FPU_NORM_CLAMP_EN
         s1_max_shift <= in_max_shift;
`endif
      end else if (s2_adv) begin
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= s1_vld;
      end
   end

   // S2 register: normalize on advance, clear valid when consumed, else hold
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         out_vld   <= 1'b0;
         out_mant  <= 64'h0;
         out_lead0 <= 6'd0;
         out_shift <= 6'd0;
         out_zero  <= 1'b0;
         out_tag   <= 4'h0;
      end else if (s2_adv) begin
         out_vld   <= 1'b1;
         out_mant  <= s1_mant << shift_sel;
         out_lead0 <= s1_lead0;
         out_shift <= shift_sel;
         out_zero  <= s1_zero;
         out_tag   <= s1_tag;
      end else if (out_rdy) begin
         out_vld <= 1'b0;
      end else begin
         out_vld <= out_vld;
      end
   end

endmodule

// File: tb/tb_fpu_norm_lead0_pipe.sv
// Directed and randomized bench for fpu_norm_lead0_pipe with a FIFO
// scoreboard of expected results. Define FPU_NORM_CLAMP_EN to cover the clamp.
module tb_fpu_norm_lead0_pipe;

   logic        rclk = 1'b0;
   logic        arst_l = 1'b0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [63:0] in_mant = 64'h0;
   logic [3:0]  in_tag = 4'h0;
   logic [5:0]  in_max_shift = 6'd63;
   logic        out_vld;
   logic        out_rdy = 1'b0;
   logic [63:0] out_mant;
   logic [5:0]  out_lead0;
   logic [5:0]  out_shift;
   logic        out_zero;
   logic [3:0]  out_tag;

   fpu_norm_lead0_pipe dut (
      .rclk         (rclk),
      .arst_l       (arst_l),
      .in_vld       (in_vld),
      .in_rdy       (in_rdy),
      .in_mant      (in_mant),
      .in_tag       (in_tag),
`ifdef FPU_NORM_CLAMP_EN
      .in_max_shift (in_max_shift),
`endif
      .out_vld      (out_vld),
      .out_rdy      (out_rdy),
      .out_mant     (out_mant),
      .out_lead0    (out_lead0),
      .out_shift    (out_shift),
      .out_zero     (out_zero),
      .out_tag      (out_tag)
   );

   always #5 rclk = ~rclk;

   typedef struct {
      logic [63:0] mant;
      logic [5:0]  lead0;
      logic [5:0]  shift;
      logic        zero;
      logic [3:0]  tag;
   } exp_t;

   exp_t sbq[$];
   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   // outputs observed in the most recent cycle
   logic        obs_vld, obs_in_rdy, obs_zero;
   logic [63:0] obs_mant;
   logic [5:0]  obs_lead0, obs_shift;
   logic [3:0]  obs_tag;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Reference: scan from the MSB for the first one
   function automatic exp_t model(input logic [63:0] m, input logic [3:0] t, input logic [5:0] ms);
      exp_t e;
      int   n;
      n = 0;
      for (int b = 63; b >= 0; b--) begin
         if (m[b]) break;
         n++;
      end
      e.zero  = (n == 64);
      e.lead0 = (n == 64) ? 6'd63 : 6'(n);
      e.shift = e.lead0;
`ifdef FPU_NORM_CLAMP_EN
      if (ms < e.lead0) e.shift = ms;
`endif
      e.mant = m << e.shift;
      e.tag  = t;
      return e;
   endfunction

   // One clock cycle: starts 1 time unit after a rising edge, ends the same
   task automatic drive_cycle(input logic v, input logic [63:0] m, input logic [3:0] t,
                              input logic [5:0] ms, input logic r,
                              output logic acc, output logic oxf);
      exp_t e;
      in_vld = v; in_mant = m; in_tag = t; in_max_shift = ms; out_rdy = r;
      #1;
      obs_vld = out_vld; obs_in_rdy = in_rdy; obs_mant = out_mant;
      obs_lead0 = out_lead0; obs_shift = out_shift; obs_zero = out_zero; obs_tag = out_tag;
      acc = in_vld & in_rdy;
      oxf = out_vld & out_rdy;
      if (oxf) begin
         if (sbq.size() == 0) begin
            check("spurious_out", {63'd0, out_vld}, 64'd0);
         end else begin
            e = sbq.pop_front();
            check("sb_tag", {60'd0, out_tag}, {60'd0, e.tag});
            check("sb_mant", out_mant, e.mant);
            check("sb_lead0", {58'd0, out_lead0}, {58'd0, e.lead0});
            check("sb_shift", {58'd0, out_shift}, {58'd0, e.shift});
            check("sb_zero", {63'd0, out_zero}, {63'd0, e.zero});
         end
      end
      if (acc) sbq.push_back(model(m, t, ms));
      cyc++;
      @(posedge rclk);
      #1;
   endtask

   // Send one op with out_rdy high and compare against hand-computed values
   task automatic run_one(input string name, input logic [63:0] m, input logic [3:0] t,
                          input logic [5:0] ms, input logic [63:0] xm, input logic [5:0] xl,
                          input logic [5:0] xs, input logic xz);
      logic acc, oxf;
      int   waited;
      drive_cycle(1'b1, m, t, ms, 1'b1, acc, oxf);
      check({name, "_accept"}, {63'd0, acc}, 64'd1);
      waited = 0;
      oxf = 1'b0;
      while (!oxf && waited < 10) begin
         drive_cycle(1'b0, 64'h0, 4'h0, 6'd63, 1'b1, acc, oxf);
         waited++;
      end
      check({name, "_latency"}, 64'(waited), 64'd2);
      check({name, "_mant"}, obs_mant, xm);
      check({name, "_lead0"}, {58'd0, obs_lead0}, {58'd0, xl});
      check({name, "_shift"}, {58'd0, obs_shift}, {58'd0, xs});
      check({name, "_zero"}, {63'd0, obs_zero}, {63'd0, xz});
      check({name, "_tag"}, {60'd0, obs_tag}, {60'd0, t});
   endtask

   task automatic drain();
      logic acc, oxf;
      for (int i = 0; i < 50 && sbq.size() > 0; i++) begin
         drive_cycle(1'b0, 64'h0, 4'h0, 6'd63, 1'b1, acc, oxf);
      end
      check("drain_empty", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc, oxf;
      logic [3:0]  t;
      logic [63:0] m, snap_mant;
      logic [3:0]  snap_tag;
      logic [5:0]  ms;
      int          accepts, outs, first_out, last_out, sent;

      // reset values while arst_l is held low
      #3;
      check("rst_out_vld", {63'd0, out_vld}, 64'd0);
      check("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
      check("rst_out_mant", out_mant, 64'h0);
      check("rst_out_tag", {60'd0, out_tag}, 64'd0);
      @(posedge rclk); #1;
      arst_l = 1'b1;

      // directed count/shift vectors
      run_one("v12345", 64'h0000_0000_0001_2345, 4'd1, 6'd63, 64'h91A2_8000_0000_0000, 6'd47, 6'd47, 1'b0);
      run_one("vmsb", 64'h8000_0000_0000_0000, 4'd2, 6'd63, 64'h8000_0000_0000_0000, 6'd0, 6'd0, 1'b0);
      run_one("vlsb", 64'h0000_0000_0000_0001, 4'd3, 6'd63, 64'h8000_0000_0000_0000, 6'd63, 6'd63, 1'b0);
      run_one("vzero", 64'h0000_0000_0000_0000, 4'd4, 6'd63, 64'h0, 6'd63, 6'd63, 1'b1);
      run_one("vff", 64'h0000_0000_0000_00FF, 4'd5, 6'd63, 64'hFF00_0000_0000_0000, 6'd56, 6'd56, 1'b0);
`ifdef FPU_NORM_CLAMP_EN
      run_one("vclamp", 64'h0000_0000_0000_00FF, 4'd6, 6'd10, 64'h0000_0000_0003_FC00, 6'd56, 6'd10, 1'b0);
`endif

      // 8 back-to-back ops, tags 0..7
      accepts = 0; outs = 0; first_out = -1; last_out = -1;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, 64'h0000_0F00_0000_0000 >> i, 4'(i), 6'd63, 1'b1, acc, oxf);
         if (acc) accepts++;
         if (oxf) begin
            outs++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
         end
      end
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b0, 64'h0, 4'h0, 6'd63, 1'b1, acc, oxf);
         if (oxf) begin
            outs++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
         end
      end
      check("b2b_accepts", 64'(accepts), 64'd8);
      check("b2b_outs", 64'(outs), 64'd8);
      check("b2b_span", 64'(last_out - first_out), 64'd7);

      // backpressure: out_rdy low for 5 cycles
      t = 4'd8; accepts = 0; snap_mant = 64'h0; snap_tag = 4'h0;
      for (int c = 0; c < 5; c++) begin
         drive_cycle(1'b1, 64'h0000_0000_00F0_0000 << t, t, 6'd63, 1'b0, acc, oxf);
         if (acc) begin accepts++; t++; end
         if (c == 2) begin snap_mant = obs_mant; snap_tag = obs_tag; end
      end
      check("bp_accepts", 64'(accepts), 64'd2);
      check("bp_in_rdy_low", {63'd0, obs_in_rdy}, 64'd0);
      check("bp_out_vld", {63'd0, obs_vld}, 64'd1);
      check("bp_hold_mant", obs_mant, snap_mant);
      check("bp_hold_tag", {60'd0, obs_tag}, {60'd0, snap_tag});
      check("bp_head_tag", {60'd0, snap_tag}, 64'd8);
      for (int c = 0; c < 40 && t < 4'd12; c++) begin
         drive_cycle(1'b1, 64'h0000_0000_00F0_0000 << t, t, 6'd63, 1'b1, acc, oxf);
         if (acc) t++;
      end
      drain();

      // reset with two ops in flight
      drive_cycle(1'b1, 64'h0000_1000_0000_0000, 4'hA, 6'd63, 1'b0, acc, oxf);
      drive_cycle(1'b1, 64'h0000_0000_1000_0000, 4'hB, 6'd63, 1'b0, acc, oxf);
      in_vld = 1'b0; out_rdy = 1'b0;
      #1;
      check("full_in_rdy", {63'd0, in_rdy}, 64'd0);
      check("full_out_vld", {63'd0, out_vld}, 64'd1);
      arst_l = 1'b0;
      #1;
      check("arst_out_vld", {63'd0, out_vld}, 64'd0);
      check("arst_in_rdy", {63'd0, in_rdy}, 64'd1);
      check("arst_out_mant", out_mant, 64'h0);
      check("arst_out_lead0", {58'd0, out_lead0}, 64'd0);
      check("arst_out_tag", {60'd0, out_tag}, 64'd0);
      sbq.delete();
      @(posedge rclk); #1;
      arst_l = 1'b1;
      run_one("post_rst", 64'h0000_0000_0001_2345, 4'hC, 6'd63, 64'h91A2_8000_0000_0000, 6'd47, 6'd47, 1'b0);

      // random handshake stress against the reference model
      sent = 0; t = 4'h0;
      m = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      ms = 6'($urandom_range(0, 63));
      for (int c = 0; c < 3000 && sent < 400; c++) begin
         drive_cycle(1'($urandom_range(0, 1)), m, t, ms, ($urandom_range(0, 3) != 0), acc, oxf);
         if (acc) begin
            sent++;
            t++;
            m = ($urandom_range(0, 15) == 0) ? 64'h0 : ({$urandom(), $urandom()} >> $urandom_range(0, 63));
            ms = 6'($urandom_range(0, 63));
         end
      end
      check("rand_sent", 64'(sent), 64'd400);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
